// File: rtl/grant_tenure_monitor_if.sv
// Request/grant bundle between agents, the tenure monitor and the arbiter.
// The master side drives raw requests and grants; the slave side (the monitor) returns masked requests and status.
interface grant_tenure_monitor_if #(
    parameter int CNT_W = 8
);
    logic             req_0;
    logic             req_1;
    logic             req_2;
    logic             req_3;
    logic             gnt_0;
    logic             gnt_1;
    logic             gnt_2;
    logic             gnt_3;
    logic             mreq_0;
    logic             mreq_1;
    logic             mreq_2;
    logic             mreq_3;
    logic [1:0]       owner;
    logic             busy;
    logic             timeout;
    logic [CNT_W-1:0] tenure;
    logic             multi_gnt;

    modport master (
        output req_0, req_1, req_2, req_3,
        output gnt_0, gnt_1, gnt_2, gnt_3,
        input  mreq_0, mreq_1, mreq_2, mreq_3,
        input  owner, busy, timeout, tenure, multi_gnt
    );

    modport slave (
        input  req_0, req_1, req_2, req_3,
        input  gnt_0, gnt_1, gnt_2, gnt_3,
        output mreq_0, mreq_1, mreq_2, mreq_3,
        output owner, busy, timeout, tenure, multi_gnt
    );
endinterface

// File: rtl/grant_tenure_monitor.sv
// Tracks how long one agent holds the arbiter grant and masks its request for a backoff window after overstaying.
// Status is registered (one-cycle latency); mreq is combinational from req, no backpressure.
module grant_tenure_monitor #(
    parameter int MAX_HOLD    = 16,
    parameter int BACKOFF_CYC = 4,
    parameter int CNT_W       = 8
) (
    input logic                   clock,
    input logic                   reset,
    grant_tenure_monitor_if.slave bus
);

    if (MAX_HOLD < 1 || MAX_HOLD > (2**CNT_W) - 1 ||
        BACKOFF_CYC < 1 || BACKOFF_CYC > (2**CNT_W) - 1) begin : g_bad_cfg
        $error("grant_tenure_monitor: illegal MAX_HOLD/BACKOFF_CYC for CNT_W");
    end

    localparam logic [CNT_W-1:0] LP_MAX     = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] LP_BO_LAST = CNT_W'(BACKOFF_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_owner;
    logic [1:0]       w_owner_nxt;
    logic [CNT_W-1:0] r_tenure;
    logic [CNT_W-1:0] w_tenure_nxt;
    logic [CNT_W-1:0] r_bcnt;
    logic [CNT_W-1:0] w_bcnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             r_multi_gnt;

    logic [3:0]       w_req;
    logic [3:0]       w_gnt;
    logic [2:0]       w_gnt_cnt;
    logic [1:0]       w_gnt_idx;
    logic             w_own_gnt;
    logic [3:0]       w_mask;

    assign w_req = {bus.req_3, bus.req_2, bus.req_1, bus.req_0};
    assign w_gnt = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};

    assign w_gnt_cnt = {2'b00, w_gnt[0]} + {2'b00, w_gnt[1]} +
                       {2'b00, w_gnt[2]} + {2'b00, w_gnt[3]};

    // Only meaningful when exactly one grant is high.
    always_comb begin
        w_gnt_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx = 2'(k);
            end
        end
    end

    assign w_own_gnt = w_gnt[r_owner];

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_tenure_nxt  = r_tenure;
        w_bcnt_nxt    = r_bcnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bcnt_nxt = '0;
                if (w_gnt_cnt == 3'd1) begin
                    w_state_nxt  = ST_HOLD;
                    w_owner_nxt  = w_gnt_idx;
                    w_tenure_nxt = CNT_W'(1);
                end else begin
                    w_tenure_nxt = '0;
                end
            end
            ST_HOLD: begin
                if (!w_own_gnt) begin
                    w_state_nxt  = ST_IDLE;
                    w_tenure_nxt = '0;
                end else if (r_tenure >= LP_MAX) begin
                    w_state_nxt   = ST_BACKOFF;
                    w_timeout_nxt = 1'b1;
                    w_bcnt_nxt    = '0;
                end else begin
                    w_tenure_nxt = r_tenure + CNT_W'(1);
                end
            end
            ST_BACKOFF: begin
                // The backoff window only starts once the offender lets go.
                if (w_own_gnt) begin
                    w_bcnt_nxt = '0;
                end else if (r_bcnt >= LP_BO_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_bcnt_nxt   = '0;
                    w_tenure_nxt = '0;
                end else begin
                    w_bcnt_nxt = r_bcnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_tenure_nxt = '0;
                w_bcnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= 2'd0;
            r_tenure    <= '0;
            r_bcnt      <= '0;
            r_timeout   <= 1'b0;
            r_multi_gnt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_tenure    <= w_tenure_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_timeout   <= w_timeout_nxt;
            r_multi_gnt <= (w_gnt_cnt > 3'd1);
        end
    end

    assign w_mask = ((r_state == ST_BACKOFF) && !reset) ? (4'b0001 << r_owner) : 4'b0000;

    assign bus.mreq_0    = w_req[0] & ~w_mask[0];
    assign bus.mreq_1    = w_req[1] & ~w_mask[1];
    assign bus.mreq_2    = w_req[2] & ~w_mask[2];
    assign bus.mreq_3    = w_req[3] & ~w_mask[3];
    assign bus.owner     = r_owner;
    assign bus.busy      = (r_state == ST_HOLD) || (r_state == ST_BACKOFF);
    assign bus.timeout   = r_timeout;
    assign bus.tenure    = r_tenure;
    assign bus.multi_gnt = r_multi_gnt;

endmodule

// File: tb/tb_grant_tenure_monitor.sv
// Directed checks of the grant tenure monitor with default parameters.
module tb_grant_tenure_monitor;

    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;
    int   n_pulse;

    grant_tenure_monitor_if #(.CNT_W(8)) bus_if ();

    grant_tenure_monitor #(
        .MAX_HOLD    (16),
        .BACKOFF_CYC (4),
        .CNT_W       (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic [3:0] v);
        bus_if.req_0 = v[0];
        bus_if.req_1 = v[1];
        bus_if.req_2 = v[2];
        bus_if.req_3 = v[3];
    endtask

    task automatic set_gnt(input logic [3:0] v);
        bus_if.gnt_0 = v[0];
        bus_if.gnt_1 = v[1];
        bus_if.gnt_2 = v[2];
        bus_if.gnt_3 = v[3];
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [3:0] mreq_v();
        return {bus_if.mreq_3, bus_if.mreq_2, bus_if.mreq_1, bus_if.mreq_0};
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        n_pulse = 0;
        reset   = 1'b1;
        set_req(4'b1010);
        set_gnt(4'b0000);
        #12;
        chk("rst_owner",   32'(bus_if.owner), 32'd0);
        chk("rst_busy",    32'(bus_if.busy), 32'd0);
        chk("rst_timeout", 32'(bus_if.timeout), 32'd0);
        chk("rst_tenure",  32'(bus_if.tenure), 32'd0);
        chk("rst_multi",   32'(bus_if.multi_gnt), 32'd0);
        chk("rst_mreq",    32'(mreq_v()), 32'hA);
        tick();
        reset = 1'b0;
        set_req(4'b0000);

        // short hold by agent 2
        set_gnt(4'b0100);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("h5_tenure",  32'(bus_if.tenure), 32'(i));
            chk("h5_owner",   32'(bus_if.owner), 32'd2);
            chk("h5_busy",    32'(bus_if.busy), 32'd1);
            chk("h5_timeout", 32'(bus_if.timeout), 32'd0);
        end
        set_gnt(4'b0000);
        tick();
        chk("h5_idle_busy",   32'(bus_if.busy), 32'd0);
        chk("h5_idle_tenure", 32'(bus_if.tenure), 32'd0);
        chk("h5_idle_owner",  32'(bus_if.owner), 32'd2);
        chk("h5_idle_tmo",    32'(bus_if.timeout), 32'd0);

        // two grants at once in IDLE
        set_gnt(4'b1001);
        tick();
        chk("mg_busy",   32'(bus_if.busy), 32'd0);
        chk("mg_multi",  32'(bus_if.multi_gnt), 32'd1);
        chk("mg_tenure", 32'(bus_if.tenure), 32'd0);
        set_gnt(4'b0001);
        tick();
        chk("mg_clr_multi", 32'(bus_if.multi_gnt), 32'd0);
        chk("mg_hold_own",  32'(bus_if.owner), 32'd0);
        chk("mg_hold_ten",  32'(bus_if.tenure), 32'd1);
        set_gnt(4'b0000);
        tick();
        chk("mg_idle", 32'(bus_if.busy), 32'd0);

        // agent 1 overstays; agent 2 grant glitch at edge 19 must not steal ownership
        set_req(4'b0110);
        for (int k = 1; k <= 20; k++) begin
            set_gnt((k == 19) ? 4'b0110 : 4'b0010);
            #1;
            chk("ov_mreq_pre", 32'(mreq_v()), (k >= 18) ? 32'h4 : 32'h6);
            tick();
            if (bus_if.timeout) n_pulse++;
            chk("ov_tenure",  32'(bus_if.tenure), (k <= 16) ? 32'(k) : 32'd16);
            chk("ov_timeout", 32'(bus_if.timeout), (k == 17) ? 32'd1 : 32'd0);
            chk("ov_owner",   32'(bus_if.owner), 32'd1);
            chk("ov_busy",    32'(bus_if.busy), 32'd1);
            chk("ov_mreq",    32'(mreq_v()), (k >= 17) ? 32'h4 : 32'h6);
            chk("ov_multi",   32'(bus_if.multi_gnt), (k == 19) ? 32'd1 : 32'd0);
        end
        set_gnt(4'b0000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (bus_if.timeout) n_pulse++;
            chk("bo_busy",   32'(bus_if.busy), (k < 4) ? 32'd1 : 32'd0);
            chk("bo_mreq",   32'(mreq_v()), (k < 4) ? 32'h4 : 32'h6);
            chk("bo_tenure", 32'(bus_if.tenure), (k < 4) ? 32'd16 : 32'd0);
        end
        chk("ov_pulses", 32'(n_pulse), 32'd1);

        // agent 0 drops right when tenure reaches the limit
        set_req(4'b0001);
        set_gnt(4'b0001);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("lim_tenure",  32'(bus_if.tenure), 32'(k));
            chk("lim_timeout", 32'(bus_if.timeout), 32'd0);
        end
        set_gnt(4'b0000);
        tick();
        chk("lim_busy",    32'(bus_if.busy), 32'd0);
        chk("lim_timeout", 32'(bus_if.timeout), 32'd0);
        chk("lim_mreq",    32'(mreq_v()), 32'h1);
        chk("lim_tenure",  32'(bus_if.tenure), 32'd0);

        // reset while agent 3 is in backoff
        set_req(4'b1000);
        set_gnt(4'b1000);
        for (int k = 1; k <= 17; k++) tick();
        chk("r3_timeout", 32'(bus_if.timeout), 32'd1);
        chk("r3_masked",  32'(mreq_v()), 32'h0);
        chk("r3_owner",   32'(bus_if.owner), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        chk("r3_rst_busy",    32'(bus_if.busy), 32'd0);
        chk("r3_rst_mreq",    32'(mreq_v()), 32'h8);
        chk("r3_rst_tenure",  32'(bus_if.tenure), 32'd0);
        chk("r3_rst_owner",   32'(bus_if.owner), 32'd0);
        chk("r3_rst_timeout", 32'(bus_if.timeout), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("r3_post_busy",   32'(bus_if.busy), 32'd1);
        chk("r3_post_owner",  32'(bus_if.owner), 32'd3);
        chk("r3_post_tenure", 32'(bus_if.tenure), 32'd1);
        chk("r3_post_mreq",   32'(mreq_v()), 32'h8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/grant_tenure_monitor.md
GRANT_TENURE_MONITOR -- requirements
Module: grant_tenure_monitor

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum consecutive cycles one agent may hold a grant.
REQ-002 SHALL have parameter BACKOFF_CYC, default 4: cycles an over-holding agent's request stays masked after its grant drops.
REQ-003 SHALL have parameter CNT_W, default 8: tenure/backoff counter width.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports req_0..req_3, input, 1 each, raw agent requests.
REQ-007 SHALL have ports gnt_0..gnt_3, input, 1 each, grants from the arbiter.
REQ-008 SHALL have ports mreq_0..mreq_3, output, 1 each, masked requests fed to the arbiter.
REQ-009 SHALL have port owner, output, 2, index of the agent currently tracked.
REQ-010 SHALL have port busy, output, 1, high in HOLD or BACKOFF.
REQ-011 SHALL have port timeout, output, 1, one-cycle pulse when a tenure limit is hit.
REQ-012 SHALL have port tenure, output, CNT_W, current hold count.
REQ-013 SHALL have port multi_gnt, output, 1, registered flag: more than one gnt seen the previous cycle.

Function
REQ-014 SHALL implement states IDLE, HOLD, BACKOFF in a registered state machine.
REQ-015 IDLE: exactly one gnt_k high -> HOLD next cycle, owner<=k, tenure<=1; zero or several gnt high -> stay IDLE, tenure<=0.
REQ-016 HOLD: gnt_owner high and tenure<MAX_HOLD -> tenure increments by 1 and stays HOLD.
REQ-017 HOLD: gnt_owner low -> IDLE next cycle, tenure<=0, no timeout.
REQ-018 HOLD: gnt_owner high and tenure==MAX_HOLD -> BACKOFF next cycle, timeout high for exactly that one cycle, tenure holds value.
REQ-019 BACKOFF: backoff counter stays 0 while gnt_owner high; once gnt_owner low it increments each cycle; reaching BACKOFF_CYC -> IDLE, counters cleared.
REQ-020 mreq_k SHALL equal req_k combinationally, except mreq_owner forced 0 throughout BACKOFF.
REQ-021 Grants to non-owner agents during HOLD/BACKOFF SHALL NOT change owner or state; they only affect multi_gnt.
REQ-022 multi_gnt SHALL be registered each cycle from the count of high gnt inputs (>1), independent of state.
REQ-023 tenure SHALL never wrap; MAX_HOLD > 2^CNT_W-1 or MAX_HOLD==0 or BACKOFF_CYC==0 is illegal configuration (elaboration check).
REQ-024 busy SHALL be decoded from state (high in HOLD or BACKOFF); owner SHALL hold its last value in IDLE.

Reset
REQ-025 reset high SHALL asynchronously force state=IDLE, owner=0, tenure=0, backoff counter=0, timeout=0, multi_gnt=0, busy=0.
REQ-026 During reset mreq_k SHALL equal req_k (no masking).
REQ-027 Reset asserted mid-HOLD or mid-BACKOFF SHALL abandon tracking; first post-reset edge behaves as IDLE.

Verification
REQ-028 gnt_2 high 5 cycles then low, MAX_HOLD=16 -> owner=2, tenure 1..5, IDLE after drop, timeout never high.
REQ-029 gnt_1 and req_1 held 20 cycles -> timeout pulses once when tenure==16; mreq_1=0 from next cycle until 4 cycles after gnt_1 drops; then IDLE, mreq_1=req_1.
REQ-030 gnt_0 and gnt_3 high same cycle in IDLE -> state stays IDLE, multi_gnt=1 next cycle, clears when only one gnt high.
REQ-031 reset asserted during BACKOFF of agent 3 -> immediately state=IDLE, mreq_3=req_3, tenure=0, without waiting for a clock edge.
REQ-032 gnt_0 drops on the cycle tenure==MAX_HOLD would be reached -> IDLE, no timeout, no masking.
